// File: rtl/i2c_cmd_queue.sv
// i2c_cmd_queue: FIFO of I2C register-write words issued one at a time to a busy-handshaking sequencer; I2C_CMD_QUEUE_OVF_CNT_EN adds an overflow counter
module i2c_cmd_queue #(
  parameter int DEPTH = 8,
  parameter int BUSY_TIMEOUT = 8,
  parameter int GAP_CYCLES = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [31:0]              in_data,
  output logic                     in_ready,
  output logic                     write,
  output logic [31:0]              data,
  input  logic                     busy,
  output logic                     pending,
  output logic [$clog2(DEPTH):0]   level,
`ifdef I2C_CMD_QUEUE_OVF_CNT_EN
  input  logic                     ovf_clr,
  output logic [15:0]              ovf_count,
`endif
  output logic                     timeout_err
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(BUSY_TIMEOUT + GAP_CYCLES + 1);
  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_ISSUE     = 3'd1;
  localparam logic [2:0] S_WAIT_BUSY = 3'd2;
  localparam logic [2:0] S_WAIT_DONE = 3'd3;
  localparam logic [2:0] S_GAP       = 3'd4;
  logic [31:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wr, r_rd;
  logic [AW:0]   r_level;
  logic [31:0]   r_data;
  logic [2:0]    r_state, w_state_nxt, w_after;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic          w_push, w_pop, w_bt_end, w_gap_end;
  assign in_ready    = r_level != (AW+1)'(DEPTH);
  assign w_push      = in_valid & in_ready;
  assign w_pop       = (r_state == S_IDLE) & (r_level != '0) & ~busy;
  assign w_after     = (GAP_CYCLES == 0) ? S_IDLE : S_GAP;
  assign w_bt_end    = r_cnt == CW'(BUSY_TIMEOUT - 1);
  assign w_gap_end   = r_cnt == CW'(GAP_CYCLES - 1);
  assign write       = r_state == S_ISSUE;
  assign data        = r_data;
  assign level       = r_level;
  assign pending     = (r_level != '0) | (r_state != S_IDLE);
  assign timeout_err = (r_state == S_WAIT_BUSY) & ~busy & w_bt_end;
  // Issue FSM: one word per busy rise/fall handshake, with busy timeout and idle guard gap
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = '0;
    case (r_state)
      S_IDLE:      w_state_nxt = w_pop ? S_ISSUE : S_IDLE;
      S_ISSUE:     w_state_nxt = S_WAIT_BUSY;
      S_WAIT_BUSY: begin
        w_state_nxt = busy ? S_WAIT_DONE : (w_bt_end ? w_after : S_WAIT_BUSY);
        w_cnt_nxt   = (busy | w_bt_end) ? '0 : r_cnt + 1'b1;
      end
      S_WAIT_DONE: w_state_nxt = busy ? S_WAIT_DONE : w_after;
      S_GAP: begin
        w_state_nxt = w_gap_end ? S_IDLE : S_GAP;
        w_cnt_nxt   = w_gap_end ? '0 : r_cnt + 1'b1;
      end
      default:     w_state_nxt = S_IDLE;
    endcase
  end
  // State, counter, FIFO pointers/occupancy and the held issue word
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_wr    <= '0;
      r_rd    <= '0;
      r_level <= '0;
      r_data  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_level <= r_level + (AW+1)'(w_push) - (AW+1)'(w_pop);
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop) begin
        r_rd   <= r_rd + 1'b1;
        r_data <= r_mem[r_rd];
      end
    end
  end
  // FIFO storage needs no reset; the pointers define what is valid
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= in_data;
  end
`ifdef I2C_CMD_QUEUE_OVF_CNT_EN
  logic [15:0] r_ovf;
  // Saturating count of cycles where the host offered a word the FIFO refused
  always_ff @(posedge clk) begin
    if (rst || ovf_clr) r_ovf <= '0;
    else if (in_valid && !in_ready && r_ovf != 16'hFFFF) r_ovf <= r_ovf + 16'd1;
  end
  assign ovf_count = r_ovf;
`endif
endmodule

// File: tb/tb_i2c_cmd_queue.sv
// tb_i2c_cmd_queue: directed self-checking bench for i2c_cmd_queue
module tb_i2c_cmd_queue;
  logic        clk = 1'b0;
  logic        rst, in_valid, busy, write, in_ready, pending, timeout_err;
  logic [31:0] in_data, data;
  logic [3:0]  level;
  int          total = 0;
  int          bad = 0;
`ifdef I2C_CMD_QUEUE_OVF_CNT_EN
  logic        ovf_clr = 1'b0;
  logic [15:0] ovf_count;
`endif
  i2c_cmd_queue dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .write(write), .data(data), .busy(busy), .pending(pending), .level(level),
`ifdef I2C_CMD_QUEUE_OVF_CNT_EN
    .ovf_clr(ovf_clr), .ovf_count(ovf_count),
`endif
    .timeout_err(timeout_err)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  // entered just after the edge that raised write; returns once the queue is back in IDLE
  task automatic serve(input int hold);
    tick();
    chk("single_pulse", {31'b0, write}, 32'd0);
    busy = 1'b1;
    repeat (hold) tick();
    busy = 1'b0;
    tick();
    tick();
    chk("gap_pending", {31'b0, pending}, 32'd1);
    chk("gap_no_write", {31'b0, write}, 32'd0);
    tick();
  endtask
  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; busy = 1'b0;
    tick();
    tick();
    chk("rst_write", {31'b0, write}, 32'd0);
    chk("rst_data", data, 32'd0);
    chk("rst_terr", {31'b0, timeout_err}, 32'd0);
    chk("rst_level", {28'b0, level}, 32'd0);
    chk("rst_pending", {31'b0, pending}, 32'd0);
    chk("rst_ready", {31'b0, in_ready}, 32'd1);
    rst = 1'b0;
    tick();
    // single word
    in_valid = 1'b1; in_data = 32'h0628_00FE;
    tick();
    in_valid = 1'b0;
    chk("sw_level", {28'b0, level}, 32'd1);
    chk("sw_nowrite", {31'b0, write}, 32'd0);
    tick();
    chk("sw_write", {31'b0, write}, 32'd1);
    chk("sw_data", data, 32'h0628_00FE);
    chk("sw_level0", {28'b0, level}, 32'd0);
    serve(20);
    chk("sw_idle_pending", {31'b0, pending}, 32'd0);
    chk("sw_data_hold", data, 32'h0628_00FE);
    // back-to-back pushes; the first is popped while the second is pushed
    in_valid = 1'b1; in_data = 32'h00AA_0101;
    tick();
    chk("b2b_lvl_a", {28'b0, level}, 32'd1);
    in_data = 32'h00BB_0202;
    tick();
    chk("b2b_lvl_b", {28'b0, level}, 32'd1);
    chk("b2b_wr_a", {31'b0, write}, 32'd1);
    chk("b2b_data_a", data, 32'h00AA_0101);
    in_data = 32'h00CC_0303;
    tick();
    in_valid = 1'b0;
    chk("b2b_lvl_c", {28'b0, level}, 32'd2);
    busy = 1'b1;
    repeat (5) tick();
    busy = 1'b0;
    repeat (3) tick();
    chk("b2b_gap_hold", {31'b0, write}, 32'd0);
    tick();
    chk("b2b_wr_b", {31'b0, write}, 32'd1);
    chk("b2b_data_b", data, 32'h00BB_0202);
    chk("b2b_lvl_1", {28'b0, level}, 32'd1);
    serve(5);
    chk("b2b_gap_hold2", {31'b0, write}, 32'd0);
    tick();
    chk("b2b_wr_c", {31'b0, write}, 32'd1);
    chk("b2b_data_c", data, 32'h00CC_0303);
    chk("b2b_lvl_0", {28'b0, level}, 32'd0);
    serve(3);
    chk("b2b_done", {31'b0, pending}, 32'd0);
    // full FIFO behind a foreign busy
    busy = 1'b1;
    tick();
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; in_data = 32'h100 + i;
      tick();
      chk("full_level", {28'b0, level}, (i < 8) ? i + 1 : 8);
      chk("full_nowrite", {31'b0, write}, 32'd0);
    end
    in_valid = 1'b0;
    chk("full_ready", {31'b0, in_ready}, 32'd0);
`ifdef I2C_CMD_QUEUE_OVF_CNT_EN
    chk("ovf_count", {16'b0, ovf_count}, 32'd2);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    chk("ovf_clr", {16'b0, ovf_count}, 32'd0);
`endif
    busy = 1'b0;
    tick();
    for (int k = 0; k < 8; k++) begin
      chk("full_wr", {31'b0, write}, 32'd1);
      chk("full_data", data, 32'h100 + k);
      serve(3);
      if (k < 7) tick();
    end
    chk("full_level0", {28'b0, level}, 32'd0);
    chk("full_pending0", {31'b0, pending}, 32'd0);
    repeat (4) begin
      tick();
      chk("full_no_extra", {31'b0, write}, 32'd0);
    end
    // busy timeout on two queued words
    in_valid = 1'b1; in_data = 32'h0011_2233;
    tick();
    in_data = 32'h0044_5566;
    tick();
    in_valid = 1'b0;
    chk("to_wr_a", {31'b0, write}, 32'd1);
    repeat (7) begin
      tick();
      chk("to_quiet", {31'b0, timeout_err}, 32'd0);
    end
    tick();
    chk("to_pulse", {31'b0, timeout_err}, 32'd1);
    tick();
    chk("to_one_pulse", {31'b0, timeout_err}, 32'd0);
    repeat (3) tick();
    chk("to_wr_b", {31'b0, write}, 32'd1);
    chk("to_data_b", data, 32'h0044_5566);
    repeat (8) tick();
    chk("to_pulse_b", {31'b0, timeout_err}, 32'd1);
    repeat (3) tick();
    chk("to_done", {31'b0, pending}, 32'd0);
    // foreign busy before a single push
    busy = 1'b1;
    in_valid = 1'b1; in_data = 32'h0077_8899;
    tick();
    in_valid = 1'b0;
    repeat (3) tick();
    chk("fb_hold", {31'b0, write}, 32'd0);
    chk("fb_level", {28'b0, level}, 32'd1);
    busy = 1'b0;
    tick();
    chk("fb_wr", {31'b0, write}, 32'd1);
    chk("fb_data", data, 32'h0077_8899);
    serve(4);
    // reset during WAIT_DONE with three words queued
    in_valid = 1'b1; in_data = 32'hA1;
    tick();
    in_data = 32'hA2;
    tick();
    in_data = 32'hA3;
    tick();
    in_data = 32'hA4; busy = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    chk("rm_level3", {28'b0, level}, 32'd3);
    chk("rm_pending", {31'b0, pending}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rm_level", {28'b0, level}, 32'd0);
    chk("rm_pending0", {31'b0, pending}, 32'd0);
    chk("rm_ready", {31'b0, in_ready}, 32'd1);
    chk("rm_write", {31'b0, write}, 32'd0);
    busy = 1'b0;
    repeat (12) begin
      tick();
      chk("rm_no_strobe", {31'b0, write | timeout_err}, 32'd0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
